exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state on rising edge.
REQ-002 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have mem_valid  in  1  instruction in MEM stage is valid and not yet retired.
REQ-004 SHALL have mem_pc  in  32  PC of the MEM instruction; mem_in_delayslot  in  1  MEM instruction is in a branch delay slot.
REQ-005 SHALL have exc_flags  in  9  one-hot-or-more flags {eret, trap, ov, ri, bp, sys, ades, adel_data, adel_fetch}, bit 8 down to bit 0.
REQ-006 SHALL have fetch_addr  in  32  faulting fetch address; data_addr  in  32  faulting load/store address.
REQ-007 SHALL have cp0_status  in  32, cp0_cause  in  32, cp0_epc  in  32: current CP0 register values.
REQ-008 SHALL have ext_int  in  6  asynchronous external interrupt lines; timer_int  in  1  CP0 timer interrupt.
REQ-009 SHALL have excepttype_o  out  32  exception code to CP0; bad_addr_o  out  32; int_o  out  6  synchronised interrupt lines to CP0.
REQ-010 SHALL have flush_o  out  1  pipeline flush; redirect_o  out  1  PC redirect strobe; newpc_o  out  32  redirect target; busy_o  out  1  stall fetch.

Function
REQ-011 SHALL pass ext_int through a 2-flop synchroniser; int_o = synchronised value (bit 5 modified per REQ-030).
REQ-012 SHALL detect interrupt pending when status[0]=1, status[1]=0, and (cause[15:8] & status[15:8]) != 0.
REQ-013 SHALL, in IDLE with mem_valid=1, select one exception by priority: interrupt > adel_fetch > ri > sys > bp > ov > trap > adel_data > ades > eret.
REQ-014 SHALL encode codes: int 0x1, adel 0x4, ades 0x5, sys 0x8, bp 0x9, ri 0xa, ov 0xc, trap 0xd, eret 0xe; none 0x0.
REQ-015 SHALL drive excepttype_o combinationally in IDLE for exactly the cycle the exception is taken; 0 in all other states.
REQ-016 SHALL drive bad_addr_o = fetch_addr for adel_fetch, data_addr for adel_data/ades, 0 otherwise.
REQ-017 SHALL use FSM IDLE -> FLUSH -> REDIRECT -> IDLE; IDLE->FLUSH on any taken exception; FLUSH and REDIRECT each last 1 cycle.
REQ-018 SHALL assert flush_o in the take cycle and in FLUSH; busy_o in FLUSH and REDIRECT.
REQ-019 SHALL latch target on take: 0xBFC00380 for all codes except eret; eret target = cp0_epc sampled in the take cycle.
REQ-020 SHALL assert redirect_o with newpc_o = latched target in REDIRECT only; newpc_o = 0 otherwise.
REQ-021 SHALL ignore mem_valid, exc_flags and interrupts while in FLUSH or REDIRECT (no nested take).
REQ-022 SHALL not take an interrupt when mem_valid=0; interrupt remains pending until a valid instruction reaches MEM.
REQ-023 SHALL take eret only when no higher-priority flag is set; simultaneous interrupt and eret: interrupt wins.
REQ-024 SHALL latency: flag in cycle N -> excepttype_o in N, redirect_o in N+2.
REQ-025 SHALL count taken exceptions in a 16-bit saturating internal counter exc_cnt (readable via hierarchy only), saturating at 0xFFFF.

Reset
REQ-026 SHALL on rst: FSM = IDLE, synchroniser flops = 0, latched target = 0, exc_cnt = 0.
REQ-027 SHALL on rst all outputs = 0 in the same cycle (excepttype_o, bad_addr_o, int_o, flush_o, redirect_o, newpc_o, busy_o).
REQ-028 SHALL abort FLUSH/REDIRECT if rst asserted mid-sequence; no redirect_o after reset.

Configuration
REQ-029 SHALL support macro TIMER_INT_MUX_EN.
REQ-030 SHALL, with TIMER_INT_MUX_EN defined, drive int_o[5] = sync_ext_int[5] | timer_int; without it, int_o[5] = sync_ext_int[5] and timer_int is unused.

Verification
REQ-031 SHALL cover: mem_valid=1, sys=1, mem_pc=0xBFC00100 -> excepttype_o=0x8 same cycle, redirect_o two cycles later, newpc_o=0xBFC00380.
REQ-032 SHALL cover: eret=1, cp0_epc=0x80001234 -> excepttype_o=0xe, newpc_o=0x80001234 at REDIRECT.
REQ-033 SHALL cover: ext_int=6'b000001, status=0x00000401, cause[10]=1 with ov=1 -> excepttype_o=0x1 (interrupt beats ov).
REQ-034 SHALL cover: adel_fetch=1 and ades=1 together, fetch_addr=0x00000003 -> excepttype_o=0x4, bad_addr_o=0x00000003.
REQ-035 SHALL cover: rst asserted in FLUSH -> next cycle IDLE, redirect_o never asserted, all outputs 0.
REQ-036 SHALL cover: TIMER_INT_MUX_EN defined, ext_int=0, timer_int=1 -> int_o=6'b100000 after 0 sync delay on bit 5 OR path; undefined -> int_o=0.

Source files
------------

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - MEM-stage exception/interrupt arbiter with flush/redirect sequencer
//
// Purpose: picks the highest-priority exception for the instruction in MEM,
// reports its code and bad address to CP0, flushes the pipeline and redirects
// fetch to the handler (or to EPC for eret) two cycles after the take.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_valid           MEM instruction valid and not yet retired
//   mem_pc              PC of MEM instruction (not needed by the arbiter)
//   mem_in_delayslot    MEM instruction in delay slot (not needed by the arbiter)
//   exc_flags[8:0]      {eret, trap, ov, ri, bp, sys, ades, adel_data, adel_fetch}
//   fetch_addr          faulting fetch address
//   data_addr           faulting load/store address
//   cp0_status/cause/epc current CP0 register values
//   ext_int[5:0]        asynchronous external interrupt lines
//   timer_int           CP0 timer interrupt
//   excepttype_o        exception code, valid only in the take cycle
//   bad_addr_o          faulting address for address-error exceptions
//   int_o[5:0]          synchronised interrupt lines to CP0
//   flush_o             pipeline flush (take cycle and FLUSH)
//   redirect_o          PC redirect strobe (REDIRECT)
//   newpc_o             redirect target (REDIRECT only)
//   busy_o              stall fetch (FLUSH and REDIRECT)
//
// Configuration macro: TIMER_INT_MUX_EN - when defined, int_o[5] also
// carries timer_int combinationally.

module exception_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic [8:0]  exc_flags,
  input  logic [31:0] fetch_addr,
  input  logic [31:0] data_addr,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic [5:0]  ext_int,
  input  logic        timer_int,
  output logic [31:0] excepttype_o,
  output logic [31:0] bad_addr_o,
  output logic [5:0]  int_o,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] newpc_o,
  output logic        busy_o
);

  localparam int F_ADEL_FETCH = 0;
  localparam int F_ADEL_DATA  = 1;
  localparam int F_ADES       = 2;
  localparam int F_SYS        = 3;
  localparam int F_BP         = 4;
  localparam int F_RI         = 5;
  localparam int F_OV         = 6;
  localparam int F_TRAP       = 7;
  localparam int F_ERET       = 8;

  localparam logic [31:0] HANDLER_PC = 32'hBFC0_0380;
  localparam logic [31:0] CODE_ERET  = 32'h0000_000e;

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t      state_q;
  logic [5:0]  sync1_q, sync2_q;
  logic [31:0] target_q, target_d;
  logic [15:0] exc_cnt;
  logic [15:0] exc_cnt_d;

  logic        int_pend;
  logic        take;
  logic [31:0] code;
  logic [31:0] bad;
  logic [5:0]  int_raw;

  // Inputs the arbiter does not look at are folded here to keep lint quiet.
  logic unused_bits;
  assign unused_bits = ^{mem_pc, mem_in_delayslot, cp0_status[31:16], cp0_status[7:2],
                         cp0_cause[31:16], cp0_cause[7:0], timer_int};

  // IE set, EXL clear, and at least one unmasked pending cause bit.
  assign int_pend = cp0_status[0] && !cp0_status[1] &&
                    ((cp0_cause[15:8] & cp0_status[15:8]) != 8'd0);

  always_comb begin
    code = 32'h0;
    bad  = 32'h0;
    if (int_pend)                    code = 32'h1;
    else if (exc_flags[F_ADEL_FETCH]) begin code = 32'h4; bad = fetch_addr; end
    else if (exc_flags[F_RI])         code = 32'ha;
    else if (exc_flags[F_SYS])        code = 32'h8;
    else if (exc_flags[F_BP])         code = 32'h9;
    else if (exc_flags[F_OV])         code = 32'hc;
    else if (exc_flags[F_TRAP])       code = 32'hd;
    else if (exc_flags[F_ADEL_DATA])  begin code = 32'h4; bad = data_addr; end
    else if (exc_flags[F_ADES])       begin code = 32'h5; bad = data_addr; end
    else if (exc_flags[F_ERET])       code = CODE_ERET;
  end

  // Only IDLE can take; FLUSH/REDIRECT ignore everything so no nested take.
  assign take = !rst && (state_q == IDLE) && mem_valid && (code != 32'h0);

  assign target_d  = (code == CODE_ERET) ? cp0_epc : HANDLER_PC;
  assign exc_cnt_d = (exc_cnt == 16'hFFFF) ? exc_cnt : exc_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync1_q  <= 6'd0;
      sync2_q  <= 6'd0;
      target_q <= 32'h0;
      exc_cnt  <= 16'd0;
    end else begin
      sync1_q <= ext_int;
      sync2_q <= sync1_q;
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q  <= FLUSH;
            target_q <= target_d;
            exc_cnt  <= exc_cnt_d;
          end
        end
        FLUSH:    state_q <= REDIRECT;
        REDIRECT: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

`ifdef TIMER_INT_MUX_EN
  assign int_raw = {sync2_q[5] | timer_int, sync2_q[4:0]};
`else
  assign int_raw = sync2_q;
`endif

  // Every output is forced low during the reset cycle itself.
  assign excepttype_o = take ? code : 32'h0;
  assign bad_addr_o   = take ? bad : 32'h0;
  assign int_o        = rst ? 6'd0 : int_raw;
  assign flush_o      = take || (!rst && state_q == FLUSH);
  assign busy_o       = !rst && (state_q != IDLE);
  assign redirect_o   = !rst && (state_q == REDIRECT);
  assign newpc_o      = redirect_o ? target_q : 32'h0;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed self-checking bench for exception_ctrl

module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delayslot;
  logic [8:0]  exc_flags;
  logic [31:0] fetch_addr, data_addr;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic [5:0]  ext_int;
  logic        timer_int;
  logic [31:0] excepttype_o, bad_addr_o, newpc_o;
  logic [5:0]  int_o;
  logic        flush_o, redirect_o, busy_o;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_in_delayslot(mem_in_delayslot), .exc_flags(exc_flags),
    .fetch_addr(fetch_addr), .data_addr(data_addr),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .ext_int(ext_int), .timer_int(timer_int),
    .excepttype_o(excepttype_o), .bad_addr_o(bad_addr_o), .int_o(int_o),
    .flush_o(flush_o), .redirect_o(redirect_o), .newpc_o(newpc_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mem_valid = 1'b0; mem_pc = 32'h0; mem_in_delayslot = 1'b0;
    exc_flags = 9'h0; fetch_addr = 32'h0; data_addr = 32'h0;
    cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
    ext_int = 6'h0; timer_int = 1'b0;
  endtask

  // Take one exception in the current IDLE cycle and follow it to IDLE again.
  // Inputs stay asserted through FLUSH/REDIRECT to show nothing is re-taken.
  task automatic run_exc(input string tag, input logic [8:0] f,
                         input logic [31:0] st, input logic [31:0] ca,
                         input logic [31:0] epc, input logic [31:0] fa,
                         input logic [31:0] da, input logic [31:0] ecode,
                         input logic [31:0] ebad, input logic [31:0] epc_exp);
    mem_valid = 1'b1; exc_flags = f; cp0_status = st; cp0_cause = ca;
    cp0_epc = epc; fetch_addr = fa; data_addr = da; mem_pc = 32'hBFC0_0100;
    #1;
    check({tag, ".code"}, excepttype_o, ecode);
    check({tag, ".bad"},  bad_addr_o, ebad);
    check({tag, ".flush0"}, {31'h0, flush_o}, 32'h1);
    check({tag, ".busy0"},  {31'h0, busy_o}, 32'h0);
    exp_cnt++;
    tick();
    check({tag, ".flcode"}, excepttype_o, 32'h0);
    check({tag, ".flush1"}, {31'h0, flush_o}, 32'h1);
    check({tag, ".busy1"},  {31'h0, busy_o}, 32'h1);
    check({tag, ".redir1"}, {31'h0, redirect_o}, 32'h0);
    tick();
    check({tag, ".redir2"}, {31'h0, redirect_o}, 32'h1);
    check({tag, ".newpc"},  newpc_o, epc_exp);
    check({tag, ".flush2"}, {31'h0, flush_o}, 32'h0);
    check({tag, ".rdcode"}, excepttype_o, 32'h0);
    clr();
    tick();
    check({tag, ".redir3"}, {31'h0, redirect_o}, 32'h0);
    check({tag, ".busy3"},  {31'h0, busy_o}, 32'h0);
    check({tag, ".newpc3"}, newpc_o, 32'h0);
  endtask

  initial begin
    clr();
    rst = 1'b1;
    mem_valid = 1'b1; exc_flags = 9'h008; ext_int = 6'h3f; timer_int = 1'b1;
    cp0_status = 32'h0000_ff01; cp0_cause = 32'h0000_ff00;
    tick(); tick();
    check("rst.code",  excepttype_o, 32'h0);
    check("rst.bad",   bad_addr_o, 32'h0);
    check("rst.int",   {26'h0, int_o}, 32'h0);
    check("rst.flush", {31'h0, flush_o}, 32'h0);
    check("rst.redir", {31'h0, redirect_o}, 32'h0);
    check("rst.newpc", newpc_o, 32'h0);
    check("rst.busy",  {31'h0, busy_o}, 32'h0);
    check("rst.cnt",   {16'h0, dut.exc_cnt}, 32'h0);
    clr();
    rst = 1'b0;
    tick();

    run_exc("sys",    9'h008, 0, 0, 0, 0, 0, 32'h8, 32'h0, 32'hBFC0_0380);
    run_exc("eret",   9'h100, 0, 0, 32'h8000_1234, 0, 0, 32'he, 32'h0, 32'h8000_1234);

    // Interrupt line through the synchroniser, then interrupt beats ov.
    ext_int = 6'b000001;
    tick();
    check("sync.1", {26'h0, int_o}, 32'h0);
    tick();
    check("sync.2", {26'h0, int_o}, 32'h1);
    run_exc("int_ov", 9'h040, 32'h0000_0401, 32'h0000_0400, 0, 0, 0, 32'h1, 32'h0, 32'hBFC0_0380);

    run_exc("adelf",  9'h005, 0, 0, 0, 32'h3, 32'h1000, 32'h4, 32'h3, 32'hBFC0_0380);
    run_exc("ades",   9'h004, 0, 0, 0, 32'h3, 32'h1002, 32'h5, 32'h1002, 32'hBFC0_0380);
    run_exc("adeld",  9'h106, 0, 0, 0, 32'h3, 32'h2001, 32'h4, 32'h2001, 32'hBFC0_0380);
    run_exc("ri_sys", 9'h028, 0, 0, 0, 0, 0, 32'ha, 32'h0, 32'hBFC0_0380);
    run_exc("bp_ov",  9'h050, 0, 0, 0, 0, 0, 32'h9, 32'h0, 32'hBFC0_0380);
    run_exc("ov_tr",  9'h0c0, 0, 0, 0, 0, 0, 32'hc, 32'h0, 32'hBFC0_0380);
    run_exc("tr_adl", 9'h082, 0, 0, 0, 0, 32'h55, 32'hd, 32'h0, 32'hBFC0_0380);
    run_exc("int_er", 9'h100, 32'h0000_8001, 32'h0000_8000, 32'h8000_0040, 0, 0, 32'h1, 32'h0, 32'hBFC0_0380);

    // Pending interrupt waits for a valid instruction.
    cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400; mem_valid = 1'b0;
    #1;
    check("nv.code",  excepttype_o, 32'h0);
    check("nv.flush", {31'h0, flush_o}, 32'h0);
    tick();
    check("nv.busy",  {31'h0, busy_o}, 32'h0);
    run_exc("nv_int", 9'h000, 32'h0000_0401, 32'h0000_0400, 0, 0, 0, 32'h1, 32'h0, 32'hBFC0_0380);

    // EXL set masks the interrupt.
    mem_valid = 1'b1; cp0_status = 32'h0000_0403; cp0_cause = 32'h0000_0400;
    #1;
    check("exl.code", excepttype_o, 32'h0);
    clr();
    tick();

    check("cnt", {16'h0, dut.exc_cnt}, exp_cnt);

    // Reset in the middle of FLUSH aborts the sequence.
    mem_valid = 1'b1; exc_flags = 9'h008;
    tick();
    check("ab.busy", {31'h0, busy_o}, 32'h1);
    rst = 1'b1;
    #1;
    check("ab.rflush", {31'h0, flush_o}, 32'h0);
    check("ab.rbusy",  {31'h0, busy_o}, 32'h0);
    check("ab.rredir", {31'h0, redirect_o}, 32'h0);
    check("ab.rcode",  excepttype_o, 32'h0);
    tick();
    rst = 1'b0;
    clr();
    exp_cnt = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("ab.redir", {31'h0, redirect_o}, 32'h0);
      check("ab.busy2", {31'h0, busy_o}, 32'h0);
      tick();
    end
    check("ab.cnt", {16'h0, dut.exc_cnt}, 32'h0);
    run_exc("post", 9'h010, 0, 0, 0, 0, 0, 32'h9, 32'h0, 32'hBFC0_0380);
    check("post.cnt", {16'h0, dut.exc_cnt}, exp_cnt);

    // Timer interrupt on bit 5 has no synchroniser delay.
    timer_int = 1'b1;
    #1;
`ifdef TIMER_INT_MUX_EN
    check("timer", {26'h0, int_o}, 32'h20);
`else
    check("timer", {26'h0, int_o}, 32'h0);
`endif
    clr();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
